// File: rtl/msrv32_branch_unit_if.sv
// Branch unit operand/decision bundle for the MSRV32 core.
// Count outputs exist only when MSRV32_BRANCH_STATS_EN is defined.
interface msrv32_branch_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] rs2_in;
    logic [6:0]      opecode_in;
    logic [2:0]      funct3_in;
    logic            branch_taken_out;
    logic            branch_taken_q_out;
`ifdef MSRV32_BRANCH_STATS_EN
    logic [31:0]     branch_count_out;
    logic [31:0]     taken_count_out;
`endif

    modport master (
        output rs1_in,
        output rs2_in,
        output opecode_in,
        output funct3_in,
`ifdef MSRV32_BRANCH_STATS_EN
        input  branch_count_out,
        input  taken_count_out,
`endif
        input  branch_taken_out,
        input  branch_taken_q_out
    );

    modport slave (
        input  rs1_in,
        input  rs2_in,
        input  opecode_in,
        input  funct3_in,
`ifdef MSRV32_BRANCH_STATS_EN
        output branch_count_out,
        output taken_count_out,
`endif
        output branch_taken_out,
        output branch_taken_q_out
    );
endinterface

// File: rtl/msrv32_branch_unit.sv
// MSRV32 branch/jump decision: combinational take flag plus registered copy.
// Define MSRV32_BRANCH_STATS_EN to add branch/taken event counters.
module msrv32_branch_unit #(
    parameter int XLEN = 32
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_in,
    msrv32_branch_unit_if.slave   bu
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic w_is_branch;
    logic w_is_jump;
    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;
    logic w_cond;
    logic w_taken;
    logic r_taken_q;

    assign w_is_branch = (bu.opecode_in == OP_BRANCH);
    assign w_is_jump   = (bu.opecode_in == OP_JAL) ||
                         (bu.opecode_in == OP_JALR);

    assign w_eq   = (bu.rs1_in == bu.rs2_in);
    assign w_lt_s = ($signed(bu.rs1_in) < $signed(bu.rs2_in));
    assign w_lt_u = (bu.rs1_in < bu.rs2_in);

    // Reserved funct3 encodings (010, 011) fall to the not-taken default.
    always_comb begin
        w_cond = 1'b0;
        case (bu.funct3_in)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt_s;
            3'b101:  w_cond = !w_lt_s;
            3'b110:  w_cond = w_lt_u;
            3'b111:  w_cond = !w_lt_u;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken = w_is_jump || (w_is_branch && w_cond);

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_taken_q <= 1'b0;
        end else begin
            r_taken_q <= w_taken;
        end
    end

    assign bu.branch_taken_out   = w_taken;
    assign bu.branch_taken_q_out = r_taken_q;

`ifdef MSRV32_BRANCH_STATS_EN
    logic [31:0] r_branch_count;
    logic [31:0] r_taken_count;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_branch_count <= 32'd0;
            r_taken_count  <= 32'd0;
        end else begin
            if (w_is_branch || w_is_jump) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_taken) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    assign bu.branch_count_out = r_branch_count;
    assign bu.taken_count_out  = r_taken_count;
`endif
endmodule

// File: tb/tb_msrv32_branch_unit.sv
// Self-checking bench for msrv32_branch_unit: decision table, reset/register
// sequences, optional counters, and randomized checks against a model.
module tb_msrv32_branch_unit;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    msrv32_branch_unit_if #(.XLEN(32)) bus ();

    msrv32_branch_unit #(.XLEN(32)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .bu                   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decision computed from the ISA rules with 64-bit integer arithmetic.
    function automatic logic model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (op == 7'b1101111 || op == 7'b1100111) return 1'b1;
        if (op != 7'b1100011) return 1'b0;
        case (f3)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        bus.opecode_in = op;
        bus.funct3_in  = f3;
        bus.rs1_in     = a;
        bus.rs2_in     = b;
    endtask

    initial begin
        logic        exp_q;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m_bcnt;
        logic [31:0] m_tcnt;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(7'd0, 3'd0, 32'd0, 32'd0);

        tbl.push_back('{"beq_eq",     7'b1100011, 3'b000, 32'h00000001, 32'h00000001, 1'b1});
        tbl.push_back('{"bne_ne",     7'b1100011, 3'b001, 32'h01111111, 32'h00000001, 1'b1});
        tbl.push_back('{"bge_lt",     7'b1100011, 3'b101, 32'h00000001, 32'h00003002, 1'b0});
        tbl.push_back('{"blt_1_2",    7'b1100011, 3'b100, 32'd1, 32'd2, 1'b1});
        tbl.push_back('{"bge_2_1",    7'b1100011, 3'b101, 32'd2, 32'd1, 1'b1});
        tbl.push_back('{"bltu_1_2",   7'b1100011, 3'b110, 32'd1, 32'd2, 1'b1});
        tbl.push_back('{"bgeu_2_1",   7'b1100011, 3'b111, 32'd2, 32'd1, 1'b1});
        tbl.push_back('{"rsv_010",    7'b1100011, 3'b010, 32'd5, 32'd5, 1'b0});
        tbl.push_back('{"rsv_011",    7'b1100011, 3'b011, 32'd1, 32'd2, 1'b0});
        tbl.push_back('{"blt_neg",    7'b1100011, 3'b100, 32'hFFFFFFFF, 32'h00000001, 1'b1});
        tbl.push_back('{"bltu_big",   7'b1100011, 3'b110, 32'hFFFFFFFF, 32'h00000001, 1'b0});
        tbl.push_back('{"bge_neg",    7'b1100011, 3'b101, 32'hFFFFFFFF, 32'h00000001, 1'b0});
        tbl.push_back('{"bgeu_big",   7'b1100011, 3'b111, 32'hFFFFFFFF, 32'h00000001, 1'b1});
        tbl.push_back('{"bne_eq",     7'b1100011, 3'b001, 32'h1234, 32'h1234, 1'b0});
        tbl.push_back('{"blt_eq",     7'b1100011, 3'b100, 32'h1234, 32'h1234, 1'b0});
        tbl.push_back('{"bgeu_eq",    7'b1100011, 3'b111, 32'h1234, 32'h1234, 1'b1});
        tbl.push_back('{"jal",        7'b1101111, 3'b010, 32'd1, 32'd9, 1'b1});
        tbl.push_back('{"jalr",       7'b1100111, 3'b111, 32'hFFFFFFFF, 32'd0, 1'b1});
        tbl.push_back('{"lui_nb",     7'b0110111, 3'b100, 32'h11000001, 32'h00001001, 1'b0});
        tbl.push_back('{"op_zero",    7'b0000000, 3'b000, 32'd0, 32'd0, 1'b0});
        tbl.push_back('{"near_br",    7'b1100001, 3'b000, 32'd3, 32'd3, 1'b0});

        // Combinational path checked while still held in reset.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].op, tbl[i].f3, tbl[i].rs1, tbl[i].rs2);
            #1;
            check(tbl[i].name, 32'(bus.branch_taken_out), 32'(tbl[i].exp));
        end

        // Register and reset sequence.
        @(negedge clk);
        drive(7'b1100011, 3'b000, 32'd7, 32'd7);
        #1;
        check("rst_comb", 32'(bus.branch_taken_out), 32'd1);
        check("rst_q", 32'(bus.branch_taken_q_out), 32'd0);
        @(posedge clk); #1;
        check("rst_q_edge", 32'(bus.branch_taken_q_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("q_after_rel", 32'(bus.branch_taken_q_out), 32'd1);
        @(negedge clk);
        drive(7'b1100011, 3'b001, 32'd7, 32'd7);
        #1;
        check("q_hold", 32'(bus.branch_taken_q_out), 32'd1);
        @(posedge clk); #1;
        check("q_not_taken", 32'(bus.branch_taken_q_out), 32'd0);
        @(negedge clk);
        drive(7'b1101111, 3'b000, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("q_jal", 32'(bus.branch_taken_q_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("q_async_clr", 32'(bus.branch_taken_q_out), 32'd0);
        check("comb_in_rst", 32'(bus.branch_taken_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MSRV32_BRANCH_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("cnt_rst_b", bus.branch_count_out, 32'd0);
        check("cnt_rst_t", bus.taken_count_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(7'b1100011, 3'b000, 32'd4, 32'd4);
        @(negedge clk);
        drive(7'b1100011, 3'b001, 32'd4, 32'd4);
        @(negedge clk);
        drive(7'b1101111, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        drive(7'b0110011, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        check("cnt_branch", bus.branch_count_out, 32'd3);
        check("cnt_taken", bus.taken_count_out, 32'd2);
        force dut.r_branch_count = 32'hFFFFFFFF;
        force dut.r_taken_count  = 32'hFFFFFFFF;
        #1;
        release dut.r_branch_count;
        release dut.r_taken_count;
        drive(7'b1100111, 3'b000, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("wrap_branch", bus.branch_count_out, 32'd0);
        check("wrap_taken", bus.taken_count_out, 32'd0);
`endif

        // Randomized run against the model, from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_bcnt = 32'd0;
        m_tcnt = 32'd0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 4))
                0, 1:    op = 7'b1100011;
                2:       op = 7'b1101111;
                3:       op = 7'b1100111;
                default: op = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = a ^ 32'h80000000;
            drive(op, f3, a, b);
            #1;
            exp_q = model(op, f3, a, b);
            check($sformatf("rnd%0d_comb", i), 32'(bus.branch_taken_out), 32'(exp_q));
            if (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111)
                m_bcnt = m_bcnt + 32'd1;
            if (exp_q) m_tcnt = m_tcnt + 32'd1;
            @(posedge clk); #1;
            check($sformatf("rnd%0d_q", i), 32'(bus.branch_taken_q_out), 32'(exp_q));
`ifdef MSRV32_BRANCH_STATS_EN
            check($sformatf("rnd%0d_bcnt", i), bus.branch_count_out, m_bcnt);
            check($sformatf("rnd%0d_tcnt", i), bus.taken_count_out, m_tcnt);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
